// File: rtl/ctrl_seq_pkg.sv
// ============================================================================
// ctrl_seq_pkg : opcode constants, FSM state and decode bundle for ctrl_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package ctrl_seq_pkg;

  localparam int OPC_W = 4;
  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t kSTR = 4'h1;
  localparam opc_t kLOD = 4'h2;
  localparam opc_t kBEQ = 4'h3;
  localparam opc_t kBNE = 4'h4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    LWAIT = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

  typedef struct packed {
    logic is_str;
    logic is_lod;
    logic is_br;
    logic is_beq;
    logic is_done;
  } dec_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// ctrl_decode : combinational instruction class decode for ctrl_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int IW     = 9,
  parameter int OPC_HI = 7,
  parameter int OPC_LO = 4
) (
  input  logic [IW-1:0] i_instr,
  output dec_t          o_dec
);

  opc_t w_opc;

  always_comb begin
    w_opc         = i_instr[OPC_HI:OPC_LO];
    o_dec.is_str  = (w_opc == kSTR);
    o_dec.is_lod  = (w_opc == kLOD);
    o_dec.is_beq  = (w_opc == kBEQ);
    o_dec.is_br   = (w_opc == kBEQ) || (w_opc == kBNE);
    // The all-ones word terminates the program regardless of its opcode field.
    o_dec.is_done = &i_instr;
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_seq.sv
// ============================================================================
// ctrl_seq : sequenced control unit with load stall, branch resolve, Start/Ack
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPC_HI  = 7,
  parameter int OPC_LO  = 4,
  parameter int MEM_LAT = 2,
  parameter int CW      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  input  logic          Zero,
  output logic          InitPc,
  output logic          PcEn,
  output logic          BranchEn,
  output logic          BranchTaken,
  output logic          RegWrEn,
  output logic          MemWrEn,
  output logic          LoadInst,
  output logic          Ack,
  output logic [CW-1:0] Retired
);

  localparam int SW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [SW-1:0] c_LOAD = SW'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_next;
  logic [CW-1:0] r_retired;
  logic          r_ack;
  logic          w_retire;
  dec_t          w_dec;

  ctrl_decode #(
    .IW     (IW),
    .OPC_HI (OPC_HI),
    .OPC_LO (OPC_LO)
  ) u_decode (
    .i_instr (Instruction),
    .o_dec   (w_dec)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_retired <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= (w_next == DONE);
      if (w_next == INIT)
        r_retired <= '0;
      else if (w_retire && (r_retired != {CW{1'b1}}))
        r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_retire    = 1'b0;
    InitPc      = 1'b0;
    PcEn        = 1'b0;
    BranchEn    = 1'b0;
    BranchTaken = 1'b0;
    RegWrEn     = 1'b0;
    MemWrEn     = 1'b0;
    LoadInst    = 1'b0;

    case (r_state)
      IDLE: begin
        if (Start) w_next = INIT;
      end
      INIT: begin
        InitPc = 1'b1;
        if (!Start) w_next = RUN;
      end
      RUN: begin
        // Start takes priority: an abort cycle issues no strobe at all.
        if (Start) begin
          w_next = INIT;
        end else if (w_dec.is_done) begin
          w_next = DONE;
        end else if (w_dec.is_str) begin
          MemWrEn  = 1'b1;
          PcEn     = 1'b1;
          w_retire = 1'b1;
        end else if (w_dec.is_lod) begin
          if (MEM_LAT == 0) begin
            RegWrEn  = 1'b1;
            LoadInst = 1'b1;
            PcEn     = 1'b1;
            w_retire = 1'b1;
          end else begin
            w_cnt_next = c_LOAD;
            w_next     = LWAIT;
          end
        end else if (w_dec.is_br) begin
          BranchEn    = 1'b1;
          BranchTaken = w_dec.is_beq ? Zero : ~Zero;
          PcEn        = 1'b1;
          w_retire    = 1'b1;
        end else begin
          RegWrEn  = 1'b1;
          PcEn     = 1'b1;
          w_retire = 1'b1;
        end
      end
      LWAIT: begin
        if (Start) begin
          w_next = INIT;
        end else begin
          LoadInst = 1'b1;
          if (r_cnt == '0) begin
            RegWrEn  = 1'b1;
            PcEn     = 1'b1;
            w_retire = 1'b1;
            w_next   = RUN;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
      end
      DONE: begin
        if (Start) w_next = INIT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign Ack     = r_ack;
  assign Retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// ============================================================================
// tb_ctrl_seq : scoreboard bench for ctrl_seq (MEM_LAT=2/CW=16 and MEM_LAT=0/CW=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  localparam logic [8:0] I_ALU  = {1'b0, 4'h8, 4'h0};
  localparam logic [8:0] I_STR  = {1'b0, kSTR, 4'h0};
  localparam logic [8:0] I_LOD  = {1'b0, kLOD, 4'h0};
  localparam logic [8:0] I_BEQ  = {1'b0, kBEQ, 4'h0};
  localparam logic [8:0] I_BNE  = {1'b0, kBNE, 4'h0};
  localparam logic [8:0] I_DONE = 9'h1FF;

  // {InitPc, PcEn, BranchEn, BranchTaken, RegWrEn, MemWrEn, LoadInst, Ack}
  localparam logic [7:0] F_NONE = 8'b0000_0000;
  localparam logic [7:0] F_INIT = 8'b1000_0000;
  localparam logic [7:0] F_ALU  = 8'b0100_1000;
  localparam logic [7:0] F_STR  = 8'b0100_0100;
  localparam logic [7:0] F_LODF = 8'b0100_1010;
  localparam logic [7:0] F_LW   = 8'b0000_0010;
  localparam logic [7:0] F_BR   = 8'b0110_0000;
  localparam logic [7:0] F_BRT  = 8'b0111_0000;
  localparam logic [7:0] F_ACK  = 8'b0000_0001;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       a_rst = 1'b1, a_start = 1'b1, a_zero = 1'b0;
  logic [8:0] a_instr = I_STR;
  logic       b_rst = 1'b1, b_start = 1'b1, b_zero = 1'b0;
  logic [8:0] b_instr = I_STR;

  logic a_init, a_pcen, a_bren, a_brt, a_rw, a_mw, a_ld, a_ack;
  logic b_init, b_pcen, b_bren, b_brt, b_rw, b_mw, b_ld, b_ack;
  logic [15:0] a_ret;
  logic [2:0]  b_ret;
  logic [23:0] obs_a, obs_b;

  assign obs_a = {a_init, a_pcen, a_bren, a_brt, a_rw, a_mw, a_ld, a_ack, a_ret};
  assign obs_b = {b_init, b_pcen, b_bren, b_brt, b_rw, b_mw, b_ld, b_ack, 13'd0, b_ret};

  ctrl_seq #(.IW(9), .OPC_HI(7), .OPC_LO(4), .MEM_LAT(2), .CW(16)) dut_a (
    .Clk(Clk), .Reset(a_rst), .Start(a_start), .Instruction(a_instr), .Zero(a_zero),
    .InitPc(a_init), .PcEn(a_pcen), .BranchEn(a_bren), .BranchTaken(a_brt),
    .RegWrEn(a_rw), .MemWrEn(a_mw), .LoadInst(a_ld), .Ack(a_ack), .Retired(a_ret)
  );

  ctrl_seq #(.IW(9), .OPC_HI(7), .OPC_LO(4), .MEM_LAT(0), .CW(3)) dut_b (
    .Clk(Clk), .Reset(b_rst), .Start(b_start), .Instruction(b_instr), .Zero(b_zero),
    .InitPc(b_init), .PcEn(b_pcen), .BranchEn(b_bren), .BranchTaken(b_brt),
    .RegWrEn(b_rw), .MemWrEn(b_mw), .LoadInst(b_ld), .Ack(b_ack), .Retired(b_ret)
  );

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, queue the expectation, compare before the next posedge.
  task automatic cyc(input int sel, input string tag, input logic rst, input logic st,
                     input logic [8:0] ins, input logic z, input logic [7:0] fl, input int ret);
    sb_t e;
    @(negedge Clk);
    if (sel == 0) begin
      a_rst = rst; a_start = st; a_instr = ins; a_zero = z;
    end else begin
      b_rst = rst; b_start = st; b_instr = ins; b_zero = z;
    end
    e.tag = tag;
    e.exp = {fl, 16'(ret)};
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    chk_val(e.tag, (sel == 0) ? obs_a : obs_b, e.exp);
  endtask

  initial begin
    // Reset dominates Start and a live store
    cyc(0, "a_rst0", 1, 1, I_STR, 0, F_NONE, 0);
    cyc(0, "a_rst1", 1, 1, I_STR, 0, F_NONE, 0);
    cyc(0, "a_idle", 0, 0, I_STR, 0, F_NONE, 0);

    // Handshake
    cyc(0, "a_st0",  0, 1, I_ALU, 0, F_NONE, 0);
    cyc(0, "a_st1",  0, 1, I_ALU, 0, F_INIT, 0);
    cyc(0, "a_st2",  0, 1, I_ALU, 0, F_INIT, 0);
    cyc(0, "a_init", 0, 0, I_ALU, 0, F_INIT, 0);

    // Program: ALU, STR, LOD (3 cycles), branches
    cyc(0, "a_alu",  0, 0, I_ALU, 0, F_ALU,  0);
    cyc(0, "a_str",  0, 0, I_STR, 0, F_STR,  1);
    cyc(0, "a_lod0", 0, 0, I_LOD, 0, F_NONE, 2);
    cyc(0, "a_lod1", 0, 0, I_LOD, 0, F_LW,   2);
    cyc(0, "a_lod2", 0, 0, I_LOD, 0, F_LODF, 2);
    cyc(0, "a_beqT", 0, 0, I_BEQ, 1, F_BRT,  3);
    cyc(0, "a_beqN", 0, 0, I_BEQ, 0, F_BR,   4);
    cyc(0, "a_bneT", 0, 0, I_BNE, 0, F_BRT,  5);
    cyc(0, "a_bneN", 0, 0, I_BNE, 1, F_BR,   6);

    // Done word and Ack
    cyc(0, "a_done", 0, 0, I_DONE, 0, F_NONE, 7);
    cyc(0, "a_ack0", 0, 0, I_DONE, 0, F_ACK,  7);
    cyc(0, "a_ack1", 0, 0, I_ALU,  0, F_ACK,  7);
    cyc(0, "a_rest", 0, 1, I_ALU,  0, F_ACK,  7);
    cyc(0, "a_rini", 0, 0, I_ALU,  0, F_INIT, 0);

    // Abort during load wait
    cyc(0, "a_ldA",  0, 0, I_LOD, 0, F_NONE, 0);
    cyc(0, "a_abrt", 0, 1, I_LOD, 0, F_NONE, 0);
    cyc(0, "a_abI",  0, 0, I_LOD, 0, F_INIT, 0);
    cyc(0, "a_alu2", 0, 0, I_ALU, 0, F_ALU,  0);

    // Reset in the middle of a load
    cyc(0, "a_ldB",  0, 0, I_LOD, 0, F_NONE, 1);
    cyc(0, "a_ldBw", 0, 0, I_LOD, 0, F_LW,   1);
    cyc(0, "a_rstM", 1, 0, I_LOD, 0, F_NONE, 0);
    cyc(0, "a_idl2", 0, 0, I_LOD, 0, F_NONE, 0);

    // Single-cycle load and Retired saturation with CW=3
    cyc(1, "b_rst",  1, 1, I_STR, 0, F_NONE, 0);
    cyc(1, "b_st",   0, 1, I_ALU, 0, F_NONE, 0);
    cyc(1, "b_init", 0, 0, I_ALU, 0, F_INIT, 0);
    cyc(1, "b_lod",  0, 0, I_LOD, 0, F_LODF, 0);
    for (int i = 1; i <= 8; i++)
      cyc(1, $sformatf("b_alu%0d", i), 0, 0, I_ALU, 0, F_ALU, (i > 7) ? 7 : i);
    cyc(1, "b_sat",  0, 0, I_DONE, 0, F_NONE, 7);
    cyc(1, "b_ack",  0, 0, I_DONE, 0, F_ACK,  7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
